multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control state machine for the multi-cycle MIPS-32 datapath. It sits directly upstream of the unified byte-addressed instruction/data memory and drives that memory's `Mem_Read`/`Mem_Write` strobes. It also drives every datapath select and write enable, sequencing each instruction through fetch, decode, execute, memory and write-back cycles.

## Interface
Parameters:
- `RST_IDLE_CYCLES`, default 1: cycles spent in `S_RST` after reset deasserts before the first fetch. Legal range 1–15.

Ports:
- `clock`, in, 1: rising-edge clock.
- `reset`, in, 1: synchronous, active-high.
- `Opcode`, in, 6: IR[31:26], valid from the `DECODE` cycle onward.
- `PC_Write`, out, 1: unconditional PC load.
- `PC_Write_Cond`, out, 1: PC load qualified by ALU Zero (beq).
- `IorD`, out, 1: memory address select. 0 = PC, 1 = ALUOut.
- `Mem_Read`, out, 1: memory read strobe.
- `Mem_Write`, out, 1: memory write strobe. The memory commits the write on the next `clock` edge.
- `IR_Write`, out, 1: instruction register load.
- `Mem_to_Reg`, out, 1: write-back data select. 1 = MDR.
- `Reg_Dst`, out, 1: destination register select. 1 = rd, 0 = rt.
- `Reg_Write`, out, 1: register file write enable.
- `ALU_Src_A`, out, 1: ALU A select. 0 = PC, 1 = rs.
- `ALU_Src_B`, out, 2: ALU B select. 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `ALU_Op`, out, 2: 00 = add, 01 = sub, 10 = decode from funct.
- `PC_Source`, out, 2: PC source select. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `Instr_Done`, out, 1: one-cycle pulse in the final state of each instruction.
- `Illegal_Op`, out, 1: high in `DECODE` when `Opcode` is unsupported.
- `State`, out, 4: current state encoding, for debug.

## Operation
State encodings, in order: `S_RST`=0, `FETCH`=1, `DECODE`=2, `MEMADR`=3, `MEMRD`=4, `MEMWB`=5, `MEMWR`=6, `EXEC`=7, `RWB`=8, `BRANCH`=9, `JUMP`=10, `ADDI_EXEC`=11, `ADDI_WB`=12. Codes 13–15 are unused and return to `S_RST`.

All outputs are Moore outputs decoded from `State`. The one exception is `Illegal_Op`, which also depends on `Opcode`. Any output not listed for a state is 0.

- **`S_RST`:** all outputs 0. An internal counter runs `RST_IDLE_CYCLES` cycles, then the FSM moves to `FETCH`.
- **`FETCH`:** `Mem_Read`=1, `IorD`=0, `IR_Write`=1, `ALU_Src_A`=0, `ALU_Src_B`=01, `ALU_Op`=00, `PC_Write`=1, `PC_Source`=00. Next state: `DECODE`.
- **`DECODE`:** `ALU_Src_A`=0, `ALU_Src_B`=11, `ALU_Op`=00, which computes the branch target. Next state by `Opcode`:
  - 0x00 → `EXEC`
  - 0x23 or 0x2B → `MEMADR`
  - 0x04 → `BRANCH`
  - 0x02 → `JUMP`
  - 0x08 → `ADDI_EXEC`, only when `MC_ADDI_EN` is defined
  - any other value → `FETCH`, with `Illegal_Op`=1
- **`MEMADR`:** `ALU_Src_A`=1, `ALU_Src_B`=10, `ALU_Op`=00. Next state: `MEMRD` if `Opcode`=0x23, else `MEMWR`.
- **`MEMRD`:** `Mem_Read`=1, `IorD`=1. Next state: `MEMWB`.
- **`MEMWB`:** `Reg_Write`=1, `Mem_to_Reg`=1, `Reg_Dst`=0, `Instr_Done`=1. Next state: `FETCH`.
- **`MEMWR`:** `Mem_Write`=1, `IorD`=1, `Instr_Done`=1. Next state: `FETCH`.
- **`EXEC`:** `ALU_Src_A`=1, `ALU_Src_B`=00, `ALU_Op`=10. Next state: `RWB`.
- **`RWB`:** `Reg_Write`=1, `Reg_Dst`=1, `Mem_to_Reg`=0, `Instr_Done`=1. Next state: `FETCH`.
- **`BRANCH`:** `ALU_Src_A`=1, `ALU_Src_B`=00, `ALU_Op`=01, `PC_Write_Cond`=1, `PC_Source`=01, `Instr_Done`=1. Next state: `FETCH`.
- **`JUMP`:** `PC_Write`=1, `PC_Source`=10, `Instr_Done`=1. Next state: `FETCH`.

Invariants:
- `Mem_Read` and `Mem_Write` are never high in the same cycle.
- `Mem_Write` is high only in `MEMWR`.

## Timing
- `reset` is sampled at each rising edge. An asserted reset forces `S_RST` and clears the idle counter at that edge, from any state, including in the middle of an instruction.
- A `MEMWR` state interrupted by reset still presents `Mem_Write`=1 for that cycle's edge. Reset does not cancel a write already in flight.
- Cycles per instruction: lw 5, sw 4, R-type 4, beq 3, j 3, addi 4, illegal 2.
- `Instr_Done` pulses exactly once per legal instruction.
- `Opcode` must be stable from `DECODE` until the instruction's final state. The FSM reads it in both `DECODE` and `MEMADR`.
- Because outputs are decoded from state, they change only after a clock edge, never combinationally from `Opcode` (except `Illegal_Op`).

## Configuration
- `MC_ADDI_EN` defined: opcode 0x08 is supported.
  - `ADDI_EXEC`: `ALU_Src_A`=1, `ALU_Src_B`=10, `ALU_Op`=00.
  - `ADDI_WB`: `Reg_Write`=1, `Reg_Dst`=0, `Mem_to_Reg`=0, `Instr_Done`=1.
- `MC_ADDI_EN` not defined: opcode 0x08 is illegal. States 11 and 12 are unreachable and decode as unused codes, returning to `S_RST`.

## Test plan
- **Reset release:** hold `reset` 3 cycles, then release with `RST_IDLE_CYCLES`=1 → `State`=0 with all outputs 0 during reset and for 1 cycle after, then `State`=1 with `Mem_Read`=1, `IR_Write`=1, `PC_Write`=1.
- **R-type:** `Opcode`=0x00 → state sequence 1,2,7,8; `ALU_Op`=10 in `EXEC`; `Reg_Write`=`Reg_Dst`=`Instr_Done`=1 only in `RWB`.
- **Loads and stores:** `Opcode`=0x23 → sequence 1,2,3,4,5, with `IorD`=1 in `MEMRD`. `Opcode`=0x2B → sequence 1,2,3,6, with `Mem_Write`=1 for exactly one cycle.
- **Branch and jump:** `Opcode`=0x04 → sequence 1,2,9 with `PC_Write_Cond`=1, `PC_Source`=01. `Opcode`=0x02 → sequence 1,2,10 with `PC_Write`=1, `PC_Source`=10.
- **Illegal opcode:** `Opcode`=0x3F → `Illegal_Op`=1 in `DECODE`, next state `FETCH`, `Instr_Done` never asserted. `Opcode`=0x08 gives the same result without `MC_ADDI_EN`; with `MC_ADDI_EN` it gives sequence 1,2,11,12.
- **Reset mid-instruction:** assert `reset` while in `MEMRD` → `State`=0 at the next edge, no `Reg_Write`, clean fetch after release.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS-32 datapath.
// Sequences fetch/decode/execute/memory/write-back and drives every datapath
// select, write enable and the unified memory's read/write strobes.
// Optional feature: define MC_ADDI_EN to support addi (opcode 0x08).
module multicycle_control #(
   parameter int unsigned RST_IDLE_CYCLES = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] Opcode,
   output logic       PC_Write,
   output logic       PC_Write_Cond,
   output logic       IorD,
   output logic       Mem_Read,
   output logic       Mem_Write,
   output logic       IR_Write,
   output logic       Mem_to_Reg,
   output logic       Reg_Dst,
   output logic       Reg_Write,
   output logic       ALU_Src_A,
   output logic [1:0] ALU_Src_B,
   output logic [1:0] ALU_Op,
   output logic [1:0] PC_Source,
   output logic       Instr_Done,
   output logic       Illegal_Op,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_RST     = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      MEMADR    = 4'd3,
      MEMRD     = 4'd4,
      MEMWB     = 4'd5,
      MEMWR     = 4'd6,
      EXEC      = 4'd7,
      RWB       = 4'd8,
      BRANCH    = 4'd9,
      JUMP      = 4'd10,
      ADDI_EXEC = 4'd11,
      ADDI_WB   = 4'd12
   } state_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
   } ctrl_t;

   localparam logic [3:0] IdleLast = 4'(RST_IDLE_CYCLES - 1);

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpAddi  = 6'h08;

   state_e     state_q, state_d;
   logic [3:0] idle_cnt_q, idle_cnt_d;
   ctrl_t      ctrl_q;

   // Moore control word for a given state; unlisted fields stay 0.
   function automatic ctrl_t decode_ctrl(state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.mem_read  = 1'b1;
            c.ir_write  = 1'b1;
            c.alu_src_b = 2'b01;
            c.pc_write  = 1'b1;
         end
         DECODE: c.alu_src_b = 2'b11;
         MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         MEMRD: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
         end
         MEMWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.instr_done = 1'b1;
         end
         MEMWR: begin
            c.mem_write  = 1'b1;
            c.iord       = 1'b1;
            c.instr_done = 1'b1;
         end
         EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b10;
         end
         RWB: begin
            c.reg_write  = 1'b1;
            c.reg_dst    = 1'b1;
            c.instr_done = 1'b1;
         end
         BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = 2'b01;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
            c.instr_done    = 1'b1;
         end
         JUMP: begin
            c.pc_write   = 1'b1;
            c.pc_source  = 2'b10;
            c.instr_done = 1'b1;
         end
`ifdef MC_ADDI_EN
         ADDI_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         ADDI_WB: begin
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
`endif
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic op_legal(logic [5:0] op);
      logic legal;
      case (op)
         OpRtype, OpLw, OpSw, OpBeq, OpJ: legal = 1'b1;
`ifdef MC_ADDI_EN
         OpAddi: legal = 1'b1;
`endif
         default: legal = 1'b0;
      endcase
      return legal;
   endfunction

   // Next-state and post-reset idle counter.
   always_comb begin
      state_d    = S_RST;
      idle_cnt_d = '0;
      case (state_q)
         S_RST: begin
            if (idle_cnt_q >= IdleLast) begin
               state_d = FETCH;
            end else begin
               state_d    = S_RST;
               idle_cnt_d = idle_cnt_q + 4'd1;
            end
         end
         FETCH: state_d = DECODE;
         DECODE: begin
            case (Opcode)
               OpRtype:     state_d = EXEC;
               OpLw, OpSw:  state_d = MEMADR;
               OpBeq:       state_d = BRANCH;
               OpJ:         state_d = JUMP;
`ifdef MC_ADDI_EN
               OpAddi:      state_d = ADDI_EXEC;
`endif
               default:     state_d = FETCH;
            endcase
         end
         MEMADR: state_d = (Opcode == OpLw) ? MEMRD : MEMWR;
         MEMRD:  state_d = MEMWB;
         MEMWB:  state_d = FETCH;
         MEMWR:  state_d = FETCH;
         EXEC:   state_d = RWB;
         RWB:    state_d = FETCH;
         BRANCH: state_d = FETCH;
         JUMP:   state_d = FETCH;
`ifdef MC_ADDI_EN
         ADDI_EXEC: state_d = ADDI_WB;
         ADDI_WB:   state_d = FETCH;
`endif
         default: state_d = S_RST;
      endcase
   end

   // State, idle counter and control word registered together so outputs
   // always match State and never follow Opcode combinationally.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_RST;
         idle_cnt_q <= '0;
         ctrl_q     <= '0;
      end else begin
         state_q    <= state_d;
         idle_cnt_q <= idle_cnt_d;
         ctrl_q     <= decode_ctrl(state_d);
      end
   end

   assign PC_Write      = ctrl_q.pc_write;
   assign PC_Write_Cond = ctrl_q.pc_write_cond;
   assign IorD          = ctrl_q.iord;
   assign Mem_Read      = ctrl_q.mem_read;
   assign Mem_Write     = ctrl_q.mem_write;
   assign IR_Write      = ctrl_q.ir_write;
   assign Mem_to_Reg    = ctrl_q.mem_to_reg;
   assign Reg_Dst       = ctrl_q.reg_dst;
   assign Reg_Write     = ctrl_q.reg_write;
   assign ALU_Src_A     = ctrl_q.alu_src_a;
   assign ALU_Src_B     = ctrl_q.alu_src_b;
   assign ALU_Op        = ctrl_q.alu_op;
   assign PC_Source     = ctrl_q.pc_source;
   assign Instr_Done    = ctrl_q.instr_done;
   assign Illegal_Op    = (state_q == DECODE) && !op_legal(Opcode);
   assign State         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected control
// vectors are queued as each instruction is driven, then popped and compared.
module tb_multicycle_control;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] Opcode = 6'h00;
   logic       PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, IR_Write;
   logic       Mem_to_Reg, Reg_Dst, Reg_Write, ALU_Src_A, Instr_Done, Illegal_Op;
   logic [1:0] ALU_Src_B, ALU_Op, PC_Source;
   logic [3:0] State;

   multicycle_control dut (
      .clock(clock), .reset(reset), .Opcode(Opcode),
      .PC_Write(PC_Write), .PC_Write_Cond(PC_Write_Cond), .IorD(IorD),
      .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .IR_Write(IR_Write),
      .Mem_to_Reg(Mem_to_Reg), .Reg_Dst(Reg_Dst), .Reg_Write(Reg_Write),
      .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B), .ALU_Op(ALU_Op),
      .PC_Source(PC_Source), .Instr_Done(Instr_Done), .Illegal_Op(Illegal_Op),
      .State(State)
   );

   always #5 clock = ~clock;

   // {State, PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, IR_Write,
   //  Mem_to_Reg, Reg_Dst, Reg_Write, ALU_Src_A, ALU_Src_B, ALU_Op, PC_Source,
   //  Instr_Done, Illegal_Op}
   wire [21:0] dut_vec = {State, PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write,
                          IR_Write, Mem_to_Reg, Reg_Dst, Reg_Write, ALU_Src_A,
                          ALU_Src_B, ALU_Op, PC_Source, Instr_Done, Illegal_Op};

   logic [21:0] exp_q[$];
   int checks = 0;
   int failures = 0;
   int done_seen = 0;
   int done_exp = 0;
   int rw_conflicts = 0;

   always @(negedge clock) begin
      if (Instr_Done) done_seen++;
      if (Mem_Read && Mem_Write) rw_conflicts++;
   end

   function automatic logic model_legal(logic [5:0] op);
      if (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02)
         return 1'b1;
`ifdef MC_ADDI_EN
      if (op == 6'h08) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic logic [21:0] model_vec(int st, logic [5:0] op);
      logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, done, ill;
      logic [1:0] sb, aop, ps;
      {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, done, ill} = '0;
      sb = 2'b00; aop = 2'b00; ps = 2'b00;
      case (st)
         1:  begin mr = 1; irw = 1; pw = 1; sb = 2'b01; end
         2:  begin sb = 2'b11; ill = !model_legal(op); end
         3:  begin sa = 1; sb = 2'b10; end
         4:  begin mr = 1; iord = 1; end
         5:  begin rw = 1; m2r = 1; done = 1; end
         6:  begin mw = 1; iord = 1; done = 1; end
         7:  begin sa = 1; aop = 2'b10; end
         8:  begin rw = 1; rd = 1; done = 1; end
         9:  begin sa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; done = 1; end
         10: begin pw = 1; ps = 2'b10; done = 1; end
         11: begin sa = 1; sb = 2'b10; end
         12: begin rw = 1; done = 1; end
         default: ;
      endcase
      return {4'(st), pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, done, ill};
   endfunction

   // Queue the expected per-cycle vectors for one instruction starting in FETCH.
   task automatic push_seq(input logic [5:0] op);
      exp_q.push_back(model_vec(1, op));
      exp_q.push_back(model_vec(2, op));
      case (op)
         6'h00: begin exp_q.push_back(model_vec(7, op)); exp_q.push_back(model_vec(8, op)); end
         6'h23: begin
            exp_q.push_back(model_vec(3, op));
            exp_q.push_back(model_vec(4, op));
            exp_q.push_back(model_vec(5, op));
         end
         6'h2B: begin exp_q.push_back(model_vec(3, op)); exp_q.push_back(model_vec(6, op)); end
         6'h04: exp_q.push_back(model_vec(9, op));
         6'h02: exp_q.push_back(model_vec(10, op));
`ifdef MC_ADDI_EN
         6'h08: begin exp_q.push_back(model_vec(11, op)); exp_q.push_back(model_vec(12, op)); end
`endif
         default: ;
      endcase
      if (model_legal(op)) done_exp++;
   endtask

   task automatic test_reset();
      logic [21:0] e;
      for (int i = 0; i < 3; i++) exp_q.push_back(model_vec(0, 6'h00));
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         e = exp_q.pop_front();
         checks++;
         if (dut_vec !== e) begin
            failures++;
            $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, dut_vec, e);
         end
      end
      reset = 1'b0;
      #1;
      e = model_vec(0, 6'h00);
      checks++;
      if (dut_vec !== e) begin
         failures++;
         $display("FAIL reset_idle got=%h exp=%h", dut_vec, e);
      end
      @(negedge clock);
      e = model_vec(1, 6'h00);
      checks++;
      if (dut_vec !== e) begin
         failures++;
         $display("FAIL reset_first_fetch got=%h exp=%h", dut_vec, e);
      end
   endtask

   task automatic test_rtype();
      logic [21:0] e;
      int step;
      Opcode = 6'h00;
      push_seq(6'h00);
      step = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (dut_vec !== e) begin
            failures++;
            $display("FAIL rtype step=%0d got=%h exp=%h", step, dut_vec, e);
         end
         @(negedge clock);
         step++;
      end
   endtask

   task automatic test_load_store();
      logic [5:0] ops[2];
      logic [21:0] e;
      int step;
      ops[0] = 6'h23;
      ops[1] = 6'h2B;
      foreach (ops[k]) begin
         Opcode = ops[k];
         push_seq(ops[k]);
         step = 0;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dut_vec !== e) begin
               failures++;
               $display("FAIL ldst op=%h step=%0d got=%h exp=%h", ops[k], step, dut_vec, e);
            end
            @(negedge clock);
            step++;
         end
      end
   endtask

   task automatic test_branch_jump();
      logic [5:0] ops[2];
      logic [21:0] e;
      int step;
      ops[0] = 6'h04;
      ops[1] = 6'h02;
      foreach (ops[k]) begin
         Opcode = ops[k];
         push_seq(ops[k]);
         step = 0;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dut_vec !== e) begin
               failures++;
               $display("FAIL brj op=%h step=%0d got=%h exp=%h", ops[k], step, dut_vec, e);
            end
            @(negedge clock);
            step++;
         end
      end
   endtask

   task automatic test_illegal();
      logic [5:0] ops[3];
      logic [21:0] e;
      int step;
      ops[0] = 6'h3F;
      ops[1] = 6'h08;
      ops[2] = 6'h2A;
      foreach (ops[k]) begin
         Opcode = ops[k];
         push_seq(ops[k]);
         step = 0;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dut_vec !== e) begin
               failures++;
               $display("FAIL illegal op=%h step=%0d got=%h exp=%h", ops[k], step, dut_vec, e);
            end
            @(negedge clock);
            step++;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [21:0] e;
      int step;
      Opcode = 6'h23;
      exp_q.push_back(model_vec(1, 6'h23));
      exp_q.push_back(model_vec(2, 6'h23));
      exp_q.push_back(model_vec(3, 6'h23));
      exp_q.push_back(model_vec(4, 6'h23));
      step = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (dut_vec !== e) begin
            failures++;
            $display("FAIL rst_mid step=%0d got=%h exp=%h", step, dut_vec, e);
         end
         if (exp_q.size() > 0) @(negedge clock);
         step++;
      end
      reset = 1'b1;
      @(negedge clock);
      e = model_vec(0, 6'h23);
      checks++;
      if (dut_vec !== e) begin
         failures++;
         $display("FAIL rst_mid_abort got=%h exp=%h", dut_vec, e);
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_back_to_back();
      logic [5:0] table_ops[8];
      logic [5:0] op;
      logic [21:0] e;
      int step;
      table_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h11};
      for (int n = 0; n < 24; n++) begin
         op = table_ops[$urandom_range(7, 0)];
         Opcode = op;
         push_seq(op);
         step = 0;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dut_vec !== e) begin
               failures++;
               $display("FAIL b2b n=%0d op=%h step=%0d got=%h exp=%h", n, op, step, dut_vec, e);
            end
            @(negedge clock);
            step++;
         end
      end
   endtask

   task automatic test_totals();
      checks++;
      if (done_seen !== done_exp) begin
         failures++;
         $display("FAIL instr_done_count got=%0d exp=%0d", done_seen, done_exp);
      end
      checks++;
      if (rw_conflicts !== 0) begin
         failures++;
         $display("FAIL mem_rw_exclusive got=%0d exp=0", rw_conflicts);
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_load_store();
      test_branch_jump();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      test_totals();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
